atconv_layer_mem_arbiter: RTL and testbench

//  Shares the single layer-memory port (cwr/crd/caddr_wr/caddr_rd/cdata_wr/cdata_rd/csel) between two requesters.

---
 rtl/atconv_layer_mem_arbiter_if.sv | 18 +
 rtl/atconv_layer_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_atconv_layer_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/atconv_layer_mem_arbiter_if.sv
// One requester's view of the shared layer-memory port.
// The requester drives the master side, and the arbiter drives the slave side.
// Handshake: req with its qualifiers is held stable until gnt is seen high; the transfer
// completes on the rising edge where req & gnt. Read data arrives later as a one-cycle rvalid.
interface atconv_layer_mem_arbiter_if;
    logic        req;
    logic        lock;
    logic        we;
    logic        sel;
    logic [11:0] addr;
    logic [12:0] wdata;
    logic        gnt;
    logic [12:0] rdata;
    logic        rvalid;

    modport master (output req, lock, we, sel, addr, wdata, input gnt, rdata, rvalid);
    modport slave  (input req, lock, we, sel, addr, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/atconv_layer_mem_arbiter.sv
// Two-way round-robin arbiter for the ATCONV layer memory. Bursts can be locked, and a cap limits them.
// Memory pins are registered. Read returns are tagged with their owner so that they reach the right requester.
module atconv_layer_mem_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    atconv_layer_mem_arbiter_if.slave     req0_bus,
    atconv_layer_mem_arbiter_if.slave     req1_bus,
    output logic                          cwr,
    output logic                          crd,
    output logic [11:0]                   caddr_wr,
    output logic [11:0]                   caddr_rd,
    output logic [12:0]                   cdata_wr,
    input  logic [12:0]                   cdata_rd,
    output logic                          csel,
    output logic                          busy,
    output logic [1:0]                    o_dbg_state
);
    localparam int CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_rr, w_rr_nxt;
    logic [CW-1:0] r_burst_cnt, w_burst_nxt;

    logic [1:0]  w_req, w_lock, w_we, w_sel, w_gnt, w_rvalid;
    logic [11:0] w_addr  [2];
    logic [12:0] w_wdata [2];
    logic        w_own, w_oth, w_xfer;

    assign w_req      = {req1_bus.req,  req0_bus.req};
    assign w_lock     = {req1_bus.lock, req0_bus.lock};
    assign w_we       = {req1_bus.we,   req0_bus.we};
    assign w_sel      = {req1_bus.sel,  req0_bus.sel};
    assign w_addr[0]  = req0_bus.addr;
    assign w_addr[1]  = req1_bus.addr;
    assign w_wdata[0] = req0_bus.wdata;
    assign w_wdata[1] = req1_bus.wdata;

    assign w_own    = (r_state == OWN1);
    assign w_oth    = ~w_own;
    assign w_gnt[0] = (r_state == OWN0) & w_req[0];
    assign w_gnt[1] = (r_state == OWN1) & w_req[1];
    assign w_xfer   = |w_gnt;

    assign req0_bus.gnt = w_gnt[0];
    assign req1_bus.gnt = w_gnt[1];
    assign o_dbg_state  = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr        <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr        <= w_rr_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // A lock holds the port only until the cap. After that the other side gets exactly one turn.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_req[0] && w_req[1])
                    w_state_nxt = r_rr ? OWN1 : OWN0;
                else if (w_req[0])
                    w_state_nxt = OWN0;
                else if (w_req[1])
                    w_state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (!w_req[w_own]) begin
                    w_burst_nxt = '0;
                    w_rr_nxt    = w_oth;
                    w_state_nxt = w_req[w_oth] ? (w_oth ? OWN1 : OWN0) : IDLE;
                end else if (w_lock[w_own] && (r_burst_cnt < CNT_LAST)) begin
                    w_burst_nxt = r_burst_cnt + 1'b1;
                end else begin
                    w_burst_nxt = '0;
                    if (w_req[w_oth]) begin
                        w_state_nxt = w_oth ? OWN1 : OWN0;
                        w_rr_nxt    = w_oth;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    logic          r_cwr, r_crd, r_csel;
    logic [11:0]   r_caddr_wr, r_caddr_rd;
    logic [12:0]   r_cdata_wr;
    logic [RD_LAT:0] r_pv, r_po;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cwr      <= 1'b0;
            r_crd      <= 1'b0;
            r_csel     <= 1'b0;
            r_caddr_wr <= '0;
            r_caddr_rd <= '0;
            r_cdata_wr <= '0;
            r_pv       <= '0;
            r_po       <= '0;
        end else begin
            r_cwr <= w_xfer & w_we[w_own];
            r_crd <= w_xfer & ~w_we[w_own];
            if (w_xfer) begin
                r_csel <= w_sel[w_own];
                if (w_we[w_own]) begin
                    r_caddr_wr <= w_addr[w_own];
                    r_cdata_wr <= w_wdata[w_own];
                end else begin
                    r_caddr_rd <= w_addr[w_own];
                end
            end
            // Owner tag travels alongside the read so the return lands on the issuing side.
            r_pv[0] <= w_xfer & ~w_we[w_own];
            r_po[0] <= w_own;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_po[k] <= r_po[k-1];
            end
        end
    end

    assign cwr      = r_cwr;
    assign crd      = r_crd;
    assign csel     = r_csel;
    assign caddr_wr = r_caddr_wr;
    assign caddr_rd = r_caddr_rd;
    assign cdata_wr = r_cdata_wr;

    assign w_rvalid[0]     = r_pv[RD_LAT] & ~r_po[RD_LAT];
    assign w_rvalid[1]     = r_pv[RD_LAT] &  r_po[RD_LAT];
    assign req0_bus.rvalid = w_rvalid[0];
    assign req1_bus.rvalid = w_rvalid[1];
    assign req0_bus.rdata  = w_rvalid[0] ? cdata_rd : '0;
    assign req1_bus.rdata  = w_rvalid[1] ? cdata_rd : '0;

    assign busy = (r_state != IDLE) | (|r_pv);
endmodule

// File: tb/tb_atconv_layer_mem_arbiter.sv
// Directed bench for the layer-memory arbiter. It covers grant order and timing, bursts with the cap, read return and reset.
// A behavioural memory answers crd one cycle later. Monitors log grants, pin activity and read returns.
module tb_atconv_layer_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    atconv_layer_mem_arbiter_if req0_bus();
    atconv_layer_mem_arbiter_if req1_bus();

    logic        cwr, crd, csel, busy;
    logic [11:0] caddr_wr, caddr_rd;
    logic [12:0] cdata_wr, cdata_rd;
    logic [1:0]  dbg_state;

    atconv_layer_mem_arbiter #(.MAX_BURST(16), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .req0_bus(req0_bus), .req1_bus(req1_bus),
        .cwr(cwr), .crd(crd), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .cdata_rd(cdata_rd), .csel(csel), .busy(busy),
        .o_dbg_state(dbg_state)
    );

    // Behavioural memory: unwritten words read back as a fixed pattern.
    function automatic logic [12:0] pat(input int idx);
        return 13'(idx * 7 + 'h155);
    endfunction

    logic [12:0] mem [int];
    logic [12:0] r_rd = '0;
    assign cdata_rd = r_rd;
    always @(posedge clk) begin
        if (cwr) mem[{19'b0, csel, caddr_wr}] = cdata_wr;
        if (crd) r_rd <= mem.exists({19'b0, csel, caddr_rd}) ? mem[{19'b0, csel, caddr_rd}]
                                                              : pat({19'b0, csel, caddr_rd});
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] g_log[$], m_log[$], r_log[$], exp_q[$], act_q[$];

    function automatic logic [31:0] g_ent(input int c, input int n, input logic [11:0] a);
        return {16'(c), 3'b0, 1'(n), a};
    endfunction
    function automatic logic [31:0] r_ent(input int c, input int n, input logic [12:0] d);
        return {16'(c), 2'b0, 1'(n), d};
    endfunction
    function automatic logic [31:0] m_ent(input logic we, input logic sel, input logic [11:0] a, input logic [12:0] d);
        return {5'b0, we, sel, a, d};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (req0_bus.gnt) g_log.push_back(g_ent(cyc, 0, req0_bus.addr));
            if (req1_bus.gnt) g_log.push_back(g_ent(cyc, 1, req1_bus.addr));
            if (cwr) m_log.push_back(m_ent(1'b1, csel, caddr_wr, cdata_wr));
            if (crd) m_log.push_back(m_ent(1'b0, csel, caddr_rd, 13'h0));
            if (req0_bus.rvalid) r_log.push_back(r_ent(cyc, 0, req0_bus.rdata));
            if (req1_bus.rvalid) r_log.push_back(r_ent(cyc, 1, req1_bus.rdata));
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic sb_drain(input string tag);
        check({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0)
            check(tag, 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic drive(input int n, input logic req, input logic lock, input logic we, input logic sel,
                         input logic [11:0] addr, input logic [12:0] wdata);
        if (n == 0) begin
            req0_bus.req = req; req0_bus.lock = lock; req0_bus.we = we;
            req0_bus.sel = sel; req0_bus.addr = addr; req0_bus.wdata = wdata;
        end else begin
            req1_bus.req = req; req1_bus.lock = lock; req1_bus.we = we;
            req1_bus.sel = sel; req1_bus.addr = addr; req1_bus.wdata = wdata;
        end
    endtask

    function automatic logic gnt_of(input int n);
        return (n == 0) ? req0_bus.gnt : req1_bus.gnt;
    endfunction

    // One transfer. It returns just after the edge where the transfer completed.
    task automatic xfer(input int n, input logic we, input logic sel, input logic [11:0] addr,
                        input logic [12:0] wdata, input logic lock, output int waits);
        logic got;
        got = 1'b0;
        waits = 0;
        drive(n, 1'b1, lock, we, sel, addr, wdata);
        while (!got && waits < 200) begin
            @(negedge clk);
            waits++;
            got = gnt_of(n);
        end
        if (!got) check("gnt_timeout", 64'(got), 64'd1);
        @(posedge clk); #1;
        drive(n, 1'b0, 1'b0, we, sel, addr, wdata);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        if (n >= 100) check("idle_timeout", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        g_log.delete(); m_log.delete(); r_log.delete(); exp_q.delete(); act_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c0;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 13'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 13'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", 64'({cwr, crd, csel, busy, req0_bus.gnt, req1_bus.gnt, req0_bus.rvalid, req1_bus.rvalid}), 64'd0);
        check("rst_addr", 64'({caddr_wr, caddr_rd, cdata_wr}), 64'd0);
        check("rst_rdata", 64'({req0_bus.rdata, req1_bus.rdata}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        clear_logs();

        // Single host read from IDLE.
        xfer(1, 1'b0, 1'b0, 12'h040, 13'h0, 1'b0, w);
        check("t1_gnt_latency", 64'(w), 64'd2);
        @(negedge clk);
        check("t1_crd_pins", 64'({cwr, crd, csel, caddr_rd}), 64'({1'b0, 1'b1, 1'b0, 12'h040}));
        @(negedge clk);
        check("t1_rvalid", 64'({req0_bus.rvalid, req1_bus.rvalid, req1_bus.rdata, req0_bus.rdata}),
              64'({1'b0, 1'b1, 13'h0315, 13'h0}));
        check("t1_hold", 64'({crd, caddr_rd}), 64'({1'b0, 12'h040}));
        wait_idle();

        // Both sides request at once: strict alternation with no dead cycle.
        clear_logs();
        c0 = cyc;
        fork
            begin int wa; for (int i = 0; i < 3; i++) xfer(0, 1'b1, 1'b0, 12'(12'h100 + i), 13'(13'h0A0 + i), 1'b0, wa); end
            begin int wb; for (int i = 0; i < 3; i++) xfer(1, 1'b0, 1'b0, 12'(12'h200 + i), 13'h0, 1'b0, wb); end
        join
        wait_idle();
        for (int k = 0; k < 6; k++)
            exp_q.push_back(g_ent(c0 + 1 + k, k % 2, (k % 2) ? 12'(12'h200 + k / 2) : 12'(12'h100 + k / 2)));
        act_q = g_log;
        sb_drain("t2_gnt");
        for (int k = 0; k < 6; k++)
            exp_q.push_back((k % 2) ? m_ent(1'b0, 1'b0, 12'(12'h200 + k / 2), 13'h0)
                                    : m_ent(1'b1, 1'b0, 12'(12'h100 + k / 2), 13'(13'h0A0 + k / 2)));
        act_q = m_log;
        sb_drain("t2_pins");
        for (int i = 0; i < 3; i++)
            exp_q.push_back(r_ent(c0 + 4 + 2 * i, 1, pat(32'h200 + i)));
        act_q = r_log;
        sb_drain("t2_rdata");

        // Locked 40-write burst: the cap hands one slot to the host after 16 writes.
        clear_logs();
        c0 = cyc;
        fork
            begin int wa; for (int i = 0; i < 40; i++) xfer(0, 1'b1, 1'b1, 12'(i), 13'(13'h0A00 + i), (i != 39), wa); end
            begin int wb; repeat (3) @(posedge clk); #1; xfer(1, 1'b0, 1'b1, 12'h7FF, 13'h0, 1'b0, wb); end
        join
        wait_idle();
        for (int k = 0; k < 41; k++) begin
            if (k < 16)       exp_q.push_back(g_ent(c0 + 1 + k, 0, 12'(k)));
            else if (k == 16) exp_q.push_back(g_ent(c0 + 1 + k, 1, 12'h7FF));
            else              exp_q.push_back(g_ent(c0 + 1 + k, 0, 12'(k - 1)));
        end
        act_q = g_log;
        sb_drain("t3_gnt");
        exp_q.push_back(r_ent(c0 + 19, 1, pat(32'h17FF)));
        act_q = r_log;
        sb_drain("t3_rdata");

        // Engine write followed next cycle by host read of the same word.
        clear_logs();
        c0 = cyc;
        fork
            begin int wa; xfer(0, 1'b1, 1'b0, 12'h005, 13'h0100, 1'b0, wa); end
            begin int wb; @(posedge clk); #1; xfer(1, 1'b0, 1'b0, 12'h005, 13'h0, 1'b0, wb); end
        join
        wait_idle();
        exp_q.push_back(g_ent(c0 + 1, 0, 12'h005));
        exp_q.push_back(g_ent(c0 + 2, 1, 12'h005));
        act_q = g_log;
        sb_drain("t4_gnt");
        exp_q.push_back(r_ent(c0 + 4, 1, 13'h0100));
        act_q = r_log;
        sb_drain("t4_rdata");

        // Eight back-to-back engine reads.
        clear_logs();
        c0 = cyc;
        for (int i = 0; i < 8; i++) xfer(0, 1'b0, 1'b0, 12'(12'h300 + i), 13'h0, 1'b1, w);
        @(negedge clk);
        @(negedge clk);
        check("t5_last_rvalid", 64'({req0_bus.rvalid, busy}), 64'({1'b1, 1'b1}));
        @(negedge clk);
        check("t5_busy_low", 64'({req0_bus.rvalid, busy}), 64'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(r_ent(c0 + 3 + i, 0, pat(32'h300 + i)));
        act_q = r_log;
        sb_drain("t5_rdata");
        wait_idle();

        // Reset in the middle of a three-read burst.
        clear_logs();
        xfer(0, 1'b0, 1'b0, 12'h400, 13'h0, 1'b1, w);
        xfer(0, 1'b0, 1'b0, 12'h401, 13'h0, 1'b1, w);
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h402, 13'h0);
        reset = 1'b1;
        #1;
        check("t6_rst_flags", 64'({cwr, crd, busy, req0_bus.gnt, req1_bus.gnt, req0_bus.rvalid, req1_bus.rvalid}), 64'd0);
        check("t6_rst_bus", 64'({caddr_wr, caddr_rd, csel, req0_bus.rdata}), 64'd0);
        check("t6_rst_state", 64'(dbg_state), 64'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 13'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        repeat (5) @(negedge clk);
        check("t6_no_rvalid", 64'(r_log.size()), 64'd0);
        @(posedge clk); #1;
        c0 = cyc;
        fork
            begin int wa; xfer(0, 1'b0, 1'b0, 12'h010, 13'h0, 1'b0, wa); end
            begin int wb; xfer(1, 1'b0, 1'b0, 12'h020, 13'h0, 1'b0, wb); end
        join
        wait_idle();
        exp_q.push_back(g_ent(c0 + 1, 0, 12'h010));
        exp_q.push_back(g_ent(c0 + 2, 1, 12'h020));
        act_q = g_log;
        sb_drain("t6_tie");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
